// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM trace monitor.
// The packed trace entry layout matches m_data: {ts, out, from, to}, MSB to LSB.
package fsm_mon_pkg;

  localparam int unsigned DEF_STATE_W = 2;
  localparam int unsigned DEF_TS_W    = 16;
  localparam int unsigned MAX_MASK_W  = 256;

  localparam logic [15:0] DEFAULT_LEGAL_MASK = 16'h9C63;

  typedef struct packed {
    logic [DEF_TS_W-1:0]    ts;
    logic                   out;
    logic [DEF_STATE_W-1:0] from;
    logic [DEF_STATE_W-1:0] to;
  } trace_entry_t;

  // Mask bit (from * 2^state_w + to) set means the transition is legal.
  function automatic logic legal(input logic [MAX_MASK_W-1:0] mask,
                                 input logic [7:0] from,
                                 input logic [7:0] to,
                                 input int unsigned state_w);
    logic [7:0] idx;
    idx = 8'((32'(from) << state_w) + 32'(to));
    return mask[idx];
  endfunction

endpackage

// File: rtl/fsm_mon_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module fsm_mon_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_trace_monitor.sv
// Passive monitor: detects state transitions of an observed FSM, checks them against a
// legal-transition mask and streams timestamped trace entries out through a FIFO.
import fsm_mon_pkg::*;

module fsm_trace_monitor #(
  parameter int unsigned               STATE_W    = 2,
  parameter int unsigned               TS_W       = 16,
  parameter int unsigned               DEPTH      = 8,
  parameter logic [2**(2*STATE_W)-1:0] LEGAL_MASK = DEFAULT_LEGAL_MASK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STATE_W-1:0]          state_in,
  input  logic                        out_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [TS_W+2*STATE_W:0]     m_data,
  output logic                        err_illegal,
  output logic [STATE_W-1:0]          err_from,
  output logic [STATE_W-1:0]          err_to,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt,
  output logic [2**STATE_W-1:0]       visited
);

  localparam int unsigned ENTRY_W = TS_W + 1 + 2 * STATE_W;

  logic [TS_W-1:0]    ts_q;
  logic [STATE_W-1:0] prev_state_q;
  logic               prev_valid_q;
  logic               ev_q;
  logic [ENTRY_W-1:0] ev_data_q;

  logic is_change, is_legal, pop, fifo_full, fifo_empty, drop;

  assign is_change = prev_valid_q && (state_in != prev_state_q);
  assign is_legal  = legal(MAX_MASK_W'(LEGAL_MASK), 8'(prev_state_q), 8'(state_in), STATE_W);
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign drop      = ev_q && fifo_full && !pop;

  // Events are staged one cycle so the FIFO never sees state_in combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      prev_state_q <= '0;
      prev_valid_q <= 1'b0;
      ev_q         <= 1'b0;
      ev_data_q    <= '0;
      err_illegal  <= 1'b0;
      err_from     <= '0;
      err_to       <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      visited      <= '0;
    end else begin
      ts_q              <= ts_q + 1'b1;
      prev_state_q      <= state_in;
      prev_valid_q      <= 1'b1;
      visited[state_in] <= 1'b1;
      ev_q              <= is_change;
      ev_data_q         <= {ts_q, out_in, prev_state_q, state_in};
      // Self-loops are checked too; only the first illegal transition is captured.
      if (prev_valid_q && !is_legal && !err_illegal) begin
        err_illegal <= 1'b1;
        err_from    <= prev_state_q;
        err_to      <= state_in;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  fsm_mon_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ev_q),
    .wdata (ev_data_q),
    .pop   (pop),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  stall_stable_a: assert property (@(posedge clk) disable iff (rst)
    m_valid && !m_ready |=> m_valid && $stable(m_data));

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// Directed bench for fsm_trace_monitor with hand-computed trace entries.
module tb_fsm_trace_monitor;
  import fsm_mon_pkg::*;

  localparam int unsigned EW = 21;

  logic          clk = 1'b0;
  logic          rst, out_in, m_valid, m_ready, err_illegal, overflow;
  logic [1:0]    state_in, err_from, err_to;
  logic [EW-1:0] m_data;
  logic [7:0]    drop_cnt;
  logic [3:0]    visited;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] got [$];

  always #5 clk = ~clk;

  fsm_trace_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .state_in    (state_in),
    .out_in      (out_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .err_illegal (err_illegal),
    .err_from    (err_from),
    .err_to      (err_to),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .visited     (visited)
  );

  // Record every entry accepted by the stream sink.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int unsigned ts, input logic o,
                                      input logic [1:0] f, input logic [1:0] t);
    trace_entry_t e;
    e = '{ts: ts[15:0], out: o, from: f, to: t};
    return 32'(e);
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input logic r, input logic [1:0] s, input logic o, input logic rdy);
    rst      = r;
    state_in = s;
    out_in   = o;
    m_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"},    32'(m_valid), 32'd0);
    check({tag, "_data"},     32'(m_data), 32'd0);
    check({tag, "_err"},      32'(err_illegal), 32'd0);
    check({tag, "_err_from"}, 32'(err_from), 32'd0);
    check({tag, "_err_to"},   32'(err_to), 32'd0);
    check({tag, "_ovf"},      32'(overflow), 32'd0);
    check({tag, "_drops"},    32'(drop_cnt), 32'd0);
    check({tag, "_visited"},  32'(visited), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Legal walk 0,1,2,3,0 then illegal 0->2 and 2->1.
    tick(1'b1, 2'd0, 1'b0, 1'b1);
    check_cleared("reset");
    got.delete();
    tick(1'b0, 2'd0, 1'b0, 1'b1);  // ts0
    tick(1'b0, 2'd1, 1'b1, 1'b1);  // ts1
    tick(1'b0, 2'd2, 1'b0, 1'b1);  // ts2
    tick(1'b0, 2'd3, 1'b1, 1'b1);  // ts3
    tick(1'b0, 2'd0, 1'b1, 1'b1);  // ts4
    check("walk_err", 32'(err_illegal), 32'd0);
    check("walk_visited", 32'(visited), 32'hF);
    tick(1'b0, 2'd2, 1'b0, 1'b1);  // ts5
    check("ill_err", 32'(err_illegal), 32'd1);
    check("ill_from", 32'(err_from), 32'd0);
    check("ill_to", 32'(err_to), 32'd2);
    tick(1'b0, 2'd1, 1'b1, 1'b1);  // ts6
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd1, 1'b0, 1'b1);
    check("ill_keep_from", 32'(err_from), 32'd0);
    check("ill_keep_to", 32'(err_to), 32'd2);
    check("walk_count", 32'(got.size()), 32'd6);
    check("walk_e0", got_at(0), ent(1, 1'b1, 2'd0, 2'd1));
    check("walk_e1", got_at(1), ent(2, 1'b0, 2'd1, 2'd2));
    check("walk_e2", got_at(2), ent(3, 1'b1, 2'd2, 2'd3));
    check("walk_e3", got_at(3), ent(4, 1'b1, 2'd3, 2'd0));
    check("ill_e4", got_at(4), ent(5, 1'b0, 2'd0, 2'd2));
    check("ill_e5", got_at(5), ent(6, 1'b1, 2'd2, 2'd1));
    check("walk_drained", 32'(m_valid), 32'd0);

    // Ten transitions with the sink stalled: eight kept, two dropped.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    got.delete();
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) tick(1'b0, 2'(i % 4), 1'(i % 2), 1'b0);
    tick(1'b0, 2'd2, 1'b0, 1'b0);
    tick(1'b0, 2'd2, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd2);
    check("ovf_valid", 32'(m_valid), 32'd1);
    check("ovf_head", 32'(m_data), ent(1, 1'b1, 2'd0, 2'd1));
    for (int i = 0; i < 10; i++) tick(1'b0, 2'd2, 1'b0, 1'b1);
    check("ovf_count", 32'(got.size()), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_e%0d", i), got_at(i - 1),
            ent(i, 1'(i % 2), 2'((i - 1) % 4), 2'(i % 4)));
    end
    check("ovf_err", 32'(err_illegal), 32'd0);

    // Full FIFO: push and pop land in the same cycle, nothing dropped.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    got.delete();
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b0, 2'(i % 4), 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);  // ts9: last push lands, FIFO full
    tick(1'b0, 2'd1, 1'b1, 1'b0);  // ts10: event 0->1
    tick(1'b0, 2'd1, 1'b0, 1'b1);  // ts11: push with pop
    tick(1'b0, 2'd1, 1'b0, 1'b0);
    check("pp_drops", 32'(drop_cnt), 32'd0);
    check("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'd1, 1'b0, 1'b1);
    check("pp_count", 32'(got.size()), 32'd9);
    check("pp_first", got_at(0), ent(1, 1'b0, 2'd0, 2'd1));
    check("pp_second", got_at(1), ent(2, 1'b0, 2'd1, 2'd2));
    check("pp_tail", got_at(8), ent(10, 1'b1, 2'd0, 2'd1));

    // Reset mid-operation with pending entries and an error latched.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    got.delete();
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd2, 1'b0, 1'b0);
    tick(1'b0, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    check("mid_err", 32'(err_illegal), 32'd1);
    check("mid_valid", 32'(m_valid), 32'd1);
    tick(1'b1, 2'd1, 1'b1, 1'b0);  // transition coincides with reset
    check_cleared("mid_rst");
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd2, 1'b0, 1'b1);
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_count", 32'(got.size()), 32'd0);
    check("post_rst_visited", 32'(visited), 32'h4);
    check("post_rst_err", 32'(err_illegal), 32'd0);

    // Timestamp wrap: transitions at ts 40000 and 80000 mod 65536.
    tick(1'b1, 2'd0, 1'b0, 1'b1);
    got.delete();
    for (int i = 0; i < 40000; i++) tick(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40000; i++) tick(1'b0, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 2'd0, 1'b0, 1'b1);
    check("wrap_count", 32'(got.size()), 32'd2);
    check("wrap_e0", got_at(0), ent(40000, 1'b0, 2'd0, 2'd1));
    check("wrap_e1", got_at(1), ent(14464, 1'b0, 2'd1, 2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
